// File: rtl/fifo_sync_buf.sv
// fifo_sync_buf: single-clock FIFO with occupancy count, almost-full/almost-empty
// thresholds, sticky overflow/underflow flags and a registered or
// first-word-fall-through read port.
module fifo_sync_buf #(
  parameter int DATASIZE      = 8,
  parameter int ADDRSIZE      = 4,
  parameter int AFULL_THRESH  = 12,
  parameter int AEMPTY_THRESH = 4,
  parameter int FWFT          = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                winc,
  input  logic [DATASIZE-1:0] wdata,
  input  logic                rinc,
  output logic [DATASIZE-1:0] rdata,
  output logic                wfull,
  output logic                rempty,
  output logic                almost_full,
  output logic                almost_empty,
  output logic [ADDRSIZE:0]   count,
  output logic                overflow,
  output logic                underflow,
  input  logic                clr_err
);

  localparam int DEPTH = 1 << ADDRSIZE;
  localparam logic [ADDRSIZE:0] DEPTH_C  = (ADDRSIZE+1)'(DEPTH);
  localparam logic [ADDRSIZE:0] AFULL_C  = (ADDRSIZE+1)'(AFULL_THRESH);
  localparam logic [ADDRSIZE:0] AEMPTY_C = (ADDRSIZE+1)'(AEMPTY_THRESH);

  logic [DATASIZE-1:0] mem_q [DEPTH];

  logic [ADDRSIZE:0] wptr_q, wptr_d;
  logic [ADDRSIZE:0] rptr_q, rptr_d;
  logic [ADDRSIZE:0] count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  logic                wr_ok;
  logic                rd_ok;
  logic [ADDRSIZE-1:0] waddr;
  logic [ADDRSIZE-1:0] raddr;

  // Status flags come only from the registered count, so they never depend
  // combinationally on winc/rinc.
  assign wfull        = (count_q == DEPTH_C);
  assign rempty       = (count_q == '0);
  assign almost_full  = (count_q >= AFULL_C);
  assign almost_empty = (count_q <= AEMPTY_C);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  assign wr_ok = winc & ~wfull;
  assign rd_ok = rinc & ~rempty;
  assign waddr = wptr_q[ADDRSIZE-1:0];
  assign raddr = rptr_q[ADDRSIZE-1:0];

  // Next-state for pointers, occupancy and sticky error flags.
  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q & ~clr_err;
    underflow_d = underflow_q & ~clr_err;
    if (wr_ok) wptr_d = wptr_q + 1'b1;
    if (rd_ok) rptr_d = rptr_q + 1'b1;
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // A set event beats a same-cycle clear.
    if (winc & wfull)  overflow_d  = 1'b1;
    if (rinc & rempty) underflow_d = 1'b1;
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[waddr] <= wdata;
  end

  if (FWFT != 0) begin : g_fwft
    // Head word is presented directly; forced to zero while empty.
    always_comb begin
      rdata = '0;
      if (!rempty) rdata = mem_q[raddr];
    end
  end else begin : g_reg
    logic [DATASIZE-1:0] rdata_q, rdata_d;

    // Capture the head word on an accepted read, otherwise hold.
    always_comb begin
      rdata_d = rdata_q;
      if (rd_ok) rdata_d = mem_q[raddr];
    end

    // Registered read data.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rdata_q <= '0;
      else        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;
  end

endmodule
